alu_issue: RTL
==============

# alu_issue

Issue/writeback stage directly upstream of `alu`: accepts packed register-to-register instructions over a valid/ready handshake and reads operands from a small local register file. It drives the combinational `alu` ports (`a`, `b`, `op`), captures `result`/`zero` into a sticky flag and writes the result back to the destination register. Each completed instruction is reported on a downstream response handshake. One instruction is in flight at a time; a later revision may pipeline this.

## Interface

- `WIDTH`, 8: datapath width; must match the `alu` instance.
- `NREG`, 4: register-file depth; fixed at 4 (2-bit register indices).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `instr_valid`  in  1: instruction offered.
- `instr_ready`  out  1: stage can accept; high only in IDLE.
- `instr`  in  9: `{op[8:6], rd[5:4], rs1[3:2], rs2[1:0]}`.
- `ld_valid`  in  1: direct register load strobe.
- `ld_addr`  in  2: register to load.
- `ld_data`  in  WIDTH: load value.
- `alu_a`  out  WIDTH: to `alu.a`, registered.
- `alu_b`  out  WIDTH: to `alu.b`, registered.
- `alu_op`  out  3: to `alu.op`, registered.
- `alu_result`  in  WIDTH: from `alu.result`.
- `alu_zero`  in  1: from `alu.zero`.
- `rsp_valid`  out  1: completion available.
- `rsp_ready`  in  1: downstream accepts completion.
- `rsp_data`  out  WIDTH: result written to `rd`.
- `rsp_rd`  out  2: destination index.
- `zero_flag`  out  1: `alu_zero` from the last completed instruction.

## Operation

- ALU op encoding (owned by `alu`): 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 a<<1, 111 a>>1. This block passes `op` through and does not interpret it.
- FSM states:
  - IDLE: `instr_ready`=1. When `instr_valid` is high, latch `alu_a`=R[rs1], `alu_b`=R[rs2], `alu_op`=op and `rd`, then go to EXEC.
  - EXEC: on the next edge, write R[rd]=`alu_result`, `rsp_data`=`alu_result`, `zero_flag`=`alu_zero`, set `rsp_valid`=1, then go to RESP.
  - RESP: hold all response outputs stable until `rsp_valid && rsp_ready`. Then clear `rsp_valid` and return to IDLE.
- Operand read in IDLE uses the current register contents. If a load to R[rs1] or R[rs2] happens on the same edge as acceptance, the instruction uses the old value (no bypass).
- `ld_valid` is honoured in every state.
  - Load and writeback to the same register on the same edge: writeback wins and the load is dropped.
  - Load and writeback to different registers on the same edge: both take effect.
- `rd` may equal `rs1` or `rs2`. Operands were latched earlier, so this is hazard-free.
- All arithmetic wraps to WIDTH bits inside `alu`; this block performs no arithmetic.
- Reset (asynchronous, any state): FSM to IDLE. Cleared to 0: all registers R0–R3, `alu_a`, `alu_b`, `alu_op`, `rsp_valid`, `rsp_data`, `rsp_rd`, `zero_flag`. Any in-flight instruction is discarded with no response.

## Timing

- Accept at edge N (IDLE, `instr_valid`=1). `alu_*` are valid after edge N.
- Writeback and `rsp_valid`=1 occur after edge N+1, so latency from acceptance to response is 2 cycles.
- Response consumed at edge M≥N+2 when `rsp_ready` is high. `instr_ready` returns high after edge M, so the next acceptance is no earlier than M+1.
- Best-case throughput: 1 instruction per 3 cycles.
- `instr_ready` is a pure function of state; it does not depend combinationally on `instr_valid`.
- `rsp_valid` does not depend combinationally on `rsp_ready`.
- The ALU path is combinational: from registered `alu_*` through `alu` to the register-file D inputs, within one cycle.

## Structure

- Shared package `alu_pkg`:
  - op localparams `OP_ADD` … `OP_SHR`.
  - FSM state encoding `ST_IDLE`, `ST_EXEC`, `ST_RESP`.
  - instruction field bit positions.
- Natural sub-module: `alu_regfile` (4×WIDTH, two async read ports, one write port with writeback-over-load priority).
- `alu` is instantiated by the parent, not inside this block.

## Test plan

- Reset: assert `rst_n`=0 mid-EXEC → `rsp_valid`=0, `zero_flag`=0, all registers read 0, `instr_ready`=1 after release.
- Load R1=10, R2=5. Issue op 000 rd=3 rs1=1 rs2=2 → `alu_a`=10, `alu_b`=5 one cycle after accept; after the second edge `rsp_valid`=1, `rsp_data`=15, `rsp_rd`=3, R3=15.
- With R1=10, R2=5, issue op 001 rd=0 rs1=1 rs2=1 → `rsp_data`=0, `zero_flag`=1. Then issue op 000 rd=0 rs1=1 rs2=2 → `zero_flag`=0.
- Wrap-around: R1=8'hFF, R2=8'h01, op 000 → `rsp_data`=8'h00, `zero_flag`=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → response outputs stable, `instr_ready`=0, a concurrent `instr_valid` is not accepted. Release `rsp_ready` → `instr_ready`=1 on the next cycle.
- Collision: `ld_valid` with `ld_addr`=3, `ld_data`=8'hAA on the writeback edge of an instruction with rd=3, result 8'h0F → R3=8'h0F. Repeat with `ld_addr`=2 → R2=8'hAA and R3=8'h0F.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: op codes,
// FSM state encoding and packed-instruction field positions.
package alu_pkg;

  // ALU operation codes (interpreted only by the downstream alu)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Issue FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Instruction layout: {op[8:6], rd[5:4], rs1[3:2], rs2[1:0]}
  localparam int INSTR_W = 9;
  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: NREG x WIDTH, two asynchronous read ports and one
// write path where an ALU writeback takes priority over a direct load.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ra1,
  input  logic [1:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             wb_en,
  input  logic [1:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data
);

  logic [WIDTH-1:0] regs_reg [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      // One register: writeback beats a load to the same index
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= '0;
        end else if (wb_en && (wb_addr == 2'(gi))) begin
          regs_reg[gi] <= wb_data;
        end else if (ld_en && (ld_addr == 2'(gi))) begin
          regs_reg[gi] <= ld_data;
        end
      end
    end
  endgenerate

  assign rd1 = regs_reg[ra1];
  assign rd2 = regs_reg[ra2];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage for an external combinational alu. One instruction
// in flight: IDLE (accept, read operands) -> EXEC (capture result, write
// back) -> RESP (hold response until consumed).
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ld_valid,
  input  logic [1:0]         ld_addr,
  input  logic [WIDTH-1:0]   ld_data,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [1:0]         rsp_rd,
  output logic               zero_flag
);

  logic [1:0]       state_reg;
  logic [1:0]       rd_reg;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             wb_en;

  assign instr_ready = (state_reg == ST_IDLE);
  // Writeback happens on the edge that leaves EXEC
  assign wb_en       = (state_reg == ST_EXEC);

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra1     (instr[RS1_MSB:RS1_LSB]),
    .ra2     (instr[RS2_MSB:RS2_LSB]),
    .rd1     (rs1_data),
    .rd2     (rs2_data),
    .wb_en   (wb_en),
    .wb_addr (rd_reg),
    .wb_data (alu_result),
    .ld_en   (ld_valid),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  // Issue FSM with registered alu operands and held response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rd_reg    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            alu_a     <= rs1_data;
            alu_b     <= rs2_data;
            alu_op    <= instr[OP_MSB:OP_LSB];
            rd_reg    <= instr[RD_MSB:RD_LSB];
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_result;
          rsp_rd    <= rd_reg;
          zero_flag <= alu_zero;
          rsp_valid <= 1'b1;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
